// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between NREQ requesters,
// returning each result on a single tagged response channel with per-requester carry chaining.
//
// state | meaning
// IDLE  | arbitrate; the winner's operands are registered onto the ALU on handshake
// EXEC  | ALU settled; result, carry and compare captured, carry_reg updated for arithmetic ops
// RESP  | response presented until resp_ready; ALU inputs and response data held
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_select,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ-1:0]       req_carry_in,
    input  logic [NREQ-1:0]       req_chain,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [3:0]            alu_select,
    output logic                  alu_mode,
    output logic                  alu_carry_in,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_carry_out,
    input  logic                  alu_compare,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_result,
    output logic                  resp_carry,
    output logic                  resp_compare,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  idx;
    logic            found;
    logic [NREQ-1:0] carry_reg;

    // Search upward from the pointer, wrapping; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Gated by rst so no grant is offered while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && rst && found)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            carry_reg    <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_select   <= '0;
            alu_mode     <= 1'b0;
            alu_carry_in <= 1'b0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_result  <= '0;
            resp_carry   <= 1'b0;
            resp_compare <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        alu_a        <= req_a[int'(win)*WIDTH +: WIDTH];
                        alu_b        <= req_b[int'(win)*WIDTH +: WIDTH];
                        alu_select   <= req_select[int'(win)*4 +: 4];
                        alu_mode     <= req_mode[win];
                        alu_carry_in <= req_chain[win] ? carry_reg[win] : req_carry_in[win];
                        resp_id      <= win;
                        ptr          <= IDW'((int'(win) + 1) % NREQ);
                        busy         <= 1'b1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result  <= alu_out;
                    resp_carry   <= alu_carry_out;
                    resp_compare <= alu_compare;
                    if (alu_mode)
                        carry_reg[resp_id] <= alu_carry_out;
                    resp_valid   <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the alu_* port.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [15:0] req_select;
    logic [3:0]  req_mode;
    logic [3:0]  req_carry_in;
    logic [3:0]  req_chain;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_select;
    logic        alu_mode;
    logic        alu_carry_in;
    logic [15:0] alu_out;
    logic        alu_carry_out;
    logic        alu_compare;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_result;
    logic        resp_carry;
    logic        resp_compare;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.WIDTH(16), .NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_select(req_select),
        .req_mode(req_mode), .req_carry_in(req_carry_in), .req_chain(req_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_carry(resp_carry), .resp_compare(resp_compare),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: arithmetic 9 = A+B+cin, 6 = A-B-1+cin; logic 6 = xor, 11 = and, 14 = or.
    always_comb begin
        logic [16:0] s;
        s = '0;
        if (alu_mode) begin
            case (alu_select)
                4'd9:    s = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_carry_in);
                4'd6:    s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'(alu_carry_in);
                default: s = {1'b0, alu_a} + 17'(alu_carry_in);
            endcase
        end else begin
            case (alu_select)
                4'd6:    s = {1'b0, alu_a ^ alu_b};
                4'd11:   s = {1'b0, alu_a & alu_b};
                4'd14:   s = {1'b0, alu_a | alu_b};
                default: s = {1'b0, ~alu_a};
            endcase
        end
        alu_out       = s[15:0];
        alu_carry_out = s[16];
        alu_compare   = (alu_a == alu_b);
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] sel, input logic mode, input logic cin,
                           input logic chain);
        req_a[i*16 +: 16]     = a;
        req_b[i*16 +: 16]     = b;
        req_select[i*4 +: 4]  = sel;
        req_mode[i]           = mode;
        req_carry_in[i]       = cin;
        req_chain[i]          = chain;
    endtask

    // One full transaction with resp_ready high; returns captured response and the carry fed to the ALU.
    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sel, input logic mode, input logic cin,
                          input logic chain, output logic [15:0] res, output logic car,
                          output logic cin_seen);
        int n;
        set_req(i, a, b, sel, mode, cin, chain);
        req_valid[i] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[i] && n < 20) begin
            tick();
            n++;
        end
        chk("grant", 32'(req_ready[i]), 32'd1);
        tick();
        req_valid[i] = 1'b0;
        chk("exec_busy", 32'(busy), 32'd1);
        tick();
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_id", 32'(resp_id), 32'(i));
        res      = resp_result;
        car      = resp_carry;
        cin_seen = alu_carry_in;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    logic [15:0] r;
    logic        c;
    logic        ci;
    int          rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst          = 1'b0;
        req_valid    = 4'b1111;
        req_a        = '0;
        req_b        = '0;
        req_select   = '0;
        req_mode     = '0;
        req_carry_in = '0;
        req_chain    = '0;
        resp_ready   = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_resp_result", 32'(resp_result), 32'd0);
        req_valid = '0;
        rst = 1'b1;
        tick();

        // Single op with explicit latency checks
        set_req(1, 16'h1234, 16'h0F0F, 4'd9, 1'b1, 1'b0, 1'b0);
        req_valid[1] = 1'b1;
        #1;
        chk("single_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        #1;
        chk("single_exec_ready", 32'(req_ready), 32'd0);
        chk("single_exec_rv", 32'(resp_valid), 32'd0);
        chk("single_alu_a", 32'(alu_a), 32'h1234);
        chk("single_alu_b", 32'(alu_b), 32'h0F0F);
        tick();
        chk("single_rv", 32'(resp_valid), 32'd1);
        chk("single_id", 32'(resp_id), 32'd1);
        chk("single_result", 32'(resp_result), 32'h2143);
        chk("single_carry", 32'(resp_carry), 32'd0);
        tick();
        chk("single_idle_rv", 32'(resp_valid), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Subtract with carry_in=1: 5 - 3
        run_op(1, 16'h0005, 16'h0003, 4'd6, 1'b1, 1'b1, 1'b0, r, c, ci);
        chk("sub_result", 32'(r), 32'h0002);
        chk("sub_carry", 32'(c), 32'd1);

        // Chained add on requester 2 with a logic op in between
        run_op(2, 16'hFFFF, 16'h0001, 4'd9, 1'b1, 1'b0, 1'b0, r, c, ci);
        chk("chain1_result", 32'(r), 32'h0000);
        chk("chain1_carry", 32'(c), 32'd1);
        run_op(2, 16'h00F0, 16'h0F00, 4'd14, 1'b0, 1'b0, 1'b0, r, c, ci);
        chk("logic_or_result", 32'(r), 32'h0FF0);
        run_op(2, 16'h0000, 16'h0000, 4'd9, 1'b1, 1'b0, 1'b1, r, c, ci);
        chk("chain2_alu_cin", 32'(ci), 32'd1);
        chk("chain2_result", 32'(r), 32'h0001);
        chk("chain2_carry", 32'(c), 32'd0);

        // Backpressure with requester 0 held valid
        resp_ready = 1'b0;
        set_req(0, 16'h0100, 16'h0011, 4'd9, 1'b1, 1'b0, 1'b0);
        req_valid[0] = 1'b1;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0001);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rv", 32'(resp_valid), 32'd1);
            chk("bp_result", 32'(resp_result), 32'h0111);
            chk("bp_alu_a", 32'(alu_a), 32'h0100);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_rv_before_accept", 32'(resp_valid), 32'd1);
        tick();
        chk("bp_regrant", 32'(req_ready), 32'b0001);
        chk("bp_rv_dropped", 32'(resp_valid), 32'd0);
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("bp2_rv", 32'(resp_valid), 32'd1);
        chk("bp2_id", 32'(resp_id), 32'd0);
        tick();

        // Pointer wrap: grant to 3, then 0 beats 3
        run_op(3, 16'h0001, 16'h0001, 4'd9, 1'b1, 1'b0, 1'b0, r, c, ci);
        chk("wrap_first_result", 32'(r), 32'h0002);
        req_valid = 4'b1001;
        #1;
        chk("wrap_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Reset during RESP
        run_op(2, 16'hFFFF, 16'h0001, 4'd9, 1'b1, 1'b0, 1'b0, r, c, ci);
        chk("mid_setup_carry", 32'(c), 32'd1);
        resp_ready = 1'b0;
        set_req(2, 16'h00FF, 16'h0F0F, 4'd11, 1'b0, 1'b0, 1'b0);
        req_valid[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        req_valid[0] = 1'b1;
        tick();
        chk("mid_rv_before", 32'(resp_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rv", 32'(resp_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        run_op(2, 16'h0000, 16'h0000, 4'd9, 1'b1, 1'b1, 1'b1, r, c, ci);
        chk("mid_chain_cin", 32'(ci), 32'd0);
        chk("mid_chain_result", 32'(r), 32'h0000);

        // Round robin from reset with all requesters valid
        do_reset();
        for (int i = 0; i < 4; i++)
            set_req(i, 16'(i), 16'h0010, 4'd9, 1'b1, 1'b0, 1'b0);
        req_valid = 4'b1111;
        #1;
        begin
            int ng;
            ng = 0;
            for (int cyc = 0; cyc < 15; cyc++) begin
                chk("rr_onehot", 32'($countones(req_ready) <= 1), 32'd1);
                if (req_ready != 4'b0000) begin
                    if (ng < 5) begin
                        chk("rr_id", 32'($clog2(req_ready)), 32'(rr_exp[ng]));
                        chk("rr_cycle", 32'(cyc), 32'(3 * ng));
                    end
                    ng++;
                end
                tick();
            end
            chk("rr_count", 32'(ng), 32'd5);
        end
        req_valid = '0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 16-bit ALU instance (mode/select/carry_in interface) between NREQ requesters.
- Round-robin arbitration over valid/ready request channels. Operands are registered and driven onto the ALU. The result is captured, then returned on a single response channel tagged with the requester ID.
- Keeps a per-requester carry register so a requester can chain multi-word add/subtract operations across requests.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU instance.
- NREQ, 4, number of requesters, 2..8.
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_select  in  NREQ*4  function select, same packing.
- req_mode  in  NREQ  0 = logic, 1 = arithmetic.
- req_carry_in  in  NREQ  explicit carry for unchained ops.
- req_chain  in  NREQ  1 = use the stored carry of this requester instead of req_carry_in.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_select  out  4  select to the ALU.
- alu_mode  out  1  mode to the ALU.
- alu_carry_in  out  1  carry to the ALU.
- alu_out  in  WIDTH  ALU result (combinational).
- alu_carry_out  in  1  ALU carry.
- alu_compare  in  1  ALU compare flag.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_result  out  WIDTH  captured result.
- resp_carry  out  1  captured carry.
- resp_compare  out  1  captured compare flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - req_ready, resp_valid and busy go to 0.
  - All alu_* outputs and all resp_* data go to 0.
  - The round-robin pointer goes to 0; all per-requester carry registers go to 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready asserts combinationally for the winner among the valid requesters, searching upward from the pointer and wrapping modulo NREQ.
  - On the handshake (req_valid[i] & req_ready[i]), the operands, select, mode and effective carry are registered into the alu_* outputs.
  - Effective carry = req_chain[i] ? carry_reg[i] : req_carry_in[i].
  - The ID is stored, the pointer is set to (i+1) mod NREQ, and the FSM moves to EXEC.
  - With no valid request, the FSM stays in IDLE and all req_ready are 0.
- EXEC (exactly one cycle):
  - alu_out, alu_carry_out and alu_compare are sampled into the resp_* registers.
  - carry_reg[id] is updated with alu_carry_out only when the stored mode = 1; logic ops leave carry_reg unchanged.
  - The FSM moves to RESP.
- RESP:
  - resp_valid = 1. resp_* and alu_* are held stable while resp_ready = 0.
  - On resp_ready = 1, resp_valid drops the next cycle and the FSM returns to IDLE. A new grant is possible in that IDLE cycle.
  - No bypass from RESP to EXEC.
- Throughput and latency:
  - At most one operation every 3 cycles.
  - resp_valid asserts 2 cycles after the request handshake edge.
- req_ready is 0 in EXEC and RESP. Requesters must hold req_* stable while req_valid is high and not yet granted.
- The alu_* outputs hold their last values after an operation, so they do not toggle idly.
- A requester that deasserts req_valid before being granted loses nothing; no state is recorded for it.
- Reset mid-operation (EXEC or RESP):
  - The in-flight result is discarded; resp_valid is 0 immediately (asynchronous).
  - Carry registers clear; nothing is replayed after reset.
- Widths:
  - resp_result is exactly WIDTH bits; the carry is carried separately.
  - resp_id is zero-extended from the winner index.

Test Plan:
- Single op: requester 1 sends mode=1, select=9, a=16'h1234, b=16'h0F0F, carry_in=0; resp_ready tied high -> resp_valid 2 cycles after the grant with resp_id=1, resp_result=alu_out (16'h2143 with the reference ALU), resp_carry=0; back in IDLE 1 cycle later.
- Round robin: all 4 requesters valid continuously from reset -> grants in order 0,1,2,3,0; one grant every 3 cycles; req_ready never has more than one bit set.
- Chained add:
  - Requester 2 first sends a=16'hFFFF, b=16'h0001, select=9, mode=1 -> resp_carry=1, resp_result=16'h0000.
  - Then it sends a=16'h0000, b=16'h0000 with req_chain=1 -> alu_carry_in=1 and resp_result=16'h0001.
  - A logic op in between leaves the stored carry intact.
- Backpressure: resp_ready held low 5 cycles with requester 0 valid -> resp_* and alu_* stable, req_ready stays 0; the grant happens the cycle after resp_ready goes high and the FSM is back in IDLE.
- Reset mid-op: assert rst low during RESP with resp_valid=1 -> resp_valid, busy and req_ready are 0 with no clock edge; after release, a chained request from the previous owner sees carry_in=0.
- Pointer wrap: only requester 3 valid, then requesters 0 and 3 both valid -> the second grant goes to requester 0 (pointer wrapped to 0).
